writeback_unit: RTL and testbench

Final (WB) pipeline stage of the RV32I core, directly upstream of the register file write port.
- Accepts one retiring instruction per cycle from the MEM stage.
- For loads, waits a variable number of cycles for the data-memory response, then aligns and sign- or zero-extends the returned word.
- Drives the register file's reg_write, rd and rd_write_data from registers, and exports load-pending status to the hazard logic.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_if.sv | 34 +++
 rtl/load_align.sv | 25 ++
 rtl/writeback_unit.sv | 102 ++++++++++
 tb/tb_writeback_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, result-source codes, load funct3 codes and FSM states for the writeback stage
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_IMM = 2'b11;
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    typedef enum logic {IDLE, WAIT_LOAD} wb_state_e;
endpackage

// File: rtl/wb_if.sv
// wb_if: MEM-stage request, data-memory response and register-file write bundle
//   slave  : writeback_unit side (consumes in_*/dmem_*, drives in_ready, write port, status)
//   master : MEM stage / memory / register file side
interface wb_if;
    import wb_pkg::*;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_reg_write;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [1:0]            in_wb_sel;
    logic [2:0]            in_funct3;
    logic [1:0]            in_addr_lo;
    logic [XLEN-1:0]       in_alu_result;
    logic [XLEN-1:0]       in_pc_plus4;
    logic [XLEN-1:0]       in_imm;
    logic                  dmem_rvalid;
    logic [XLEN-1:0]       dmem_rdata;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rd_write_data;
    logic                  load_pending;
    logic [REG_ADDR_W-1:0] load_pending_rd;
    logic                  protocol_err;
    modport slave (
        input  in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3, in_addr_lo,
               in_alu_result, in_pc_plus4, in_imm, dmem_rvalid, dmem_rdata,
        output in_ready, reg_write, rd, rd_write_data, load_pending, load_pending_rd, protocol_err
    );
    modport master (
        output in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3, in_addr_lo,
               in_alu_result, in_pc_plus4, in_imm, dmem_rvalid, dmem_rdata,
        input  in_ready, reg_write, rd, rd_write_data, load_pending, load_pending_rd, protocol_err
    );
endinterface

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half of a load word and sign- or zero-extends it
//   rdata_i          raw aligned memory word
//   funct3_i         load width/sign code
//   addr_lo_i        byte address [1:0]
//   data_o           extended load result (unknown codes return the full word)
//   illegal_funct3_o funct3 is not a defined load code
module load_align
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o,
    output logic            illegal_funct3_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign data_o = funct3_i == FUNCT3_LB  ? {{24{byte_sel[7]}}, byte_sel} :
                    funct3_i == FUNCT3_LH  ? {{16{half_sel[15]}}, half_sel} :
                    funct3_i == FUNCT3_LBU ? {24'b0, byte_sel} :
                    funct3_i == FUNCT3_LHU ? {16'b0, half_sel} : rdata_i;
    assign illegal_funct3_o = !(funct3_i inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU});
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: RV32I WB stage; retires one instruction per cycle, stalls on outstanding loads
//   clk, rst : clock and synchronous active-high reset
//   bus      : wb_if.slave carrying MEM-stage request, dmem response, register-file write and hazard status
module writeback_unit
    import wb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    wb_if.slave  bus
);
    wb_state_e             state_q, state_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic                  pend_q, pend_d;
    logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;
    logic                  err_q, err_d;
    logic                  ld_we_q, ld_we_d;
    logic [2:0]            ld_f3_q, ld_f3_d;
    logic [1:0]            ld_lo_q, ld_lo_d;
    logic [XLEN-1:0]       ld_data;
    logic                  ld_illegal;
    logic [XLEN-1:0]       src_data;
    // Alignment works on the captured funct3/addr_lo so the MEM stage may move on after the load is accepted.
    load_align u_align (
        .rdata_i          (bus.dmem_rdata),
        .funct3_i         (ld_f3_q),
        .addr_lo_i        (ld_lo_q),
        .data_o           (ld_data),
        .illegal_funct3_o (ld_illegal)
    );
    assign src_data = bus.in_wb_sel == WB_SEL_PC4 ? bus.in_pc_plus4 :
                      bus.in_wb_sel == WB_SEL_IMM ? bus.in_imm : bus.in_alu_result;
    always_comb begin
        state_d     = state_q;
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        data_d      = data_q;
        pend_d      = pend_q;
        pend_rd_d   = pend_rd_q;
        err_d       = err_q;
        ld_we_d     = ld_we_q;
        ld_f3_d     = ld_f3_q;
        ld_lo_d     = ld_lo_q;
        if (state_q == IDLE) begin
            // A response with no load outstanding is an orphan and is dropped.
            if (bus.dmem_rvalid) err_d = 1'b1;
            if (bus.in_valid && bus.in_wb_sel == WB_SEL_MEM) begin
                state_d   = WAIT_LOAD;
                pend_d    = 1'b1;
                pend_rd_d = bus.in_rd;
                ld_we_d   = bus.in_reg_write && bus.in_rd != '0;
                ld_f3_d   = bus.in_funct3;
                ld_lo_d   = bus.in_addr_lo;
            end else if (bus.in_valid) begin
                reg_write_d = bus.in_reg_write && bus.in_rd != '0;
                rd_d        = bus.in_rd;
                data_d      = src_data;
            end
        end else if (bus.dmem_rvalid) begin
            state_d     = IDLE;
            reg_write_d = ld_we_q;
            rd_d        = pend_rd_q;
            data_d      = ld_data;
            pend_d      = 1'b0;
            pend_rd_d   = '0;
            err_d       = err_q | ld_illegal;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            pend_q      <= 1'b0;
            pend_rd_q   <= '0;
            err_q       <= 1'b0;
            ld_we_q     <= 1'b0;
            ld_f3_q     <= '0;
            ld_lo_q     <= '0;
        end else begin
            state_q     <= state_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            pend_q      <= pend_d;
            pend_rd_q   <= pend_rd_d;
            err_q       <= err_d;
            ld_we_q     <= ld_we_d;
            ld_f3_q     <= ld_f3_d;
            ld_lo_q     <= ld_lo_d;
        end
    end
    assign bus.in_ready        = state_q == IDLE;
    assign bus.reg_write       = reg_write_q;
    assign bus.rd              = rd_q;
    assign bus.rd_write_data   = data_q;
    assign bus.load_pending    = pend_q;
    assign bus.load_pending_rd = pend_rd_q;
    assign bus.protocol_err    = err_q;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed table-driven bench for writeback_unit plus multi-cycle corner sequences
module tb_writeback_unit;
    import wb_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    wb_if bus();
    writeback_unit dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    typedef struct {
        string       name;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] src;
        int          lat;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;
    localparam int NV = 14;
    vec_t tbl [NV];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic idle_inputs();
        bus.in_valid      = 1'b0;
        bus.in_reg_write  = 1'b0;
        bus.in_rd         = '0;
        bus.in_wb_sel     = WB_SEL_ALU;
        bus.in_funct3     = '0;
        bus.in_addr_lo    = '0;
        bus.in_alu_result = 32'hA1A1_A1A1;
        bus.in_pc_plus4   = 32'hB2B2_B2B2;
        bus.in_imm        = 32'hC3C3_C3C3;
        bus.dmem_rvalid   = 1'b0;
        bus.dmem_rdata    = 32'hD4D4_D4D4;
    endtask
    task automatic present(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                           input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] src);
        idle_inputs();
        bus.in_valid     = 1'b1;
        bus.in_reg_write = rw;
        bus.in_rd        = rd;
        bus.in_wb_sel    = sel;
        bus.in_funct3    = f3;
        bus.in_addr_lo   = lo;
        if (sel == WB_SEL_ALU) bus.in_alu_result = src;
        if (sel == WB_SEL_PC4) bus.in_pc_plus4 = src;
        if (sel == WB_SEL_IMM) bus.in_imm = src;
    endtask
    initial begin
        tbl[0]  = '{"alu",       1'b1, 5'd5,  WB_SEL_ALU, 3'd0,       2'd0, 32'h0000_1234, 0, 1'b1, 32'h0000_1234};
        tbl[1]  = '{"pc4_rd0",   1'b1, 5'd0,  WB_SEL_PC4, 3'd0,       2'd0, 32'h0000_0104, 0, 1'b0, 32'h0000_0104};
        tbl[2]  = '{"imm",       1'b1, 5'd9,  WB_SEL_IMM, 3'd0,       2'd0, 32'hABCD_E000, 0, 1'b1, 32'hABCD_E000};
        tbl[3]  = '{"alu_norw",  1'b0, 5'd10, WB_SEL_ALU, 3'd0,       2'd0, 32'h0000_0055, 0, 1'b0, 32'h0000_0055};
        tbl[4]  = '{"lb_lo3",    1'b1, 5'd7,  WB_SEL_MEM, FUNCT3_LB,  2'd3, 32'h80FF_1234, 3, 1'b1, 32'hFFFF_FF80};
        tbl[5]  = '{"lhu_lo2",   1'b1, 5'd8,  WB_SEL_MEM, FUNCT3_LHU, 2'd2, 32'h80FF_1234, 2, 1'b1, 32'h0000_80FF};
        tbl[6]  = '{"lh_lo0",    1'b1, 5'd11, WB_SEL_MEM, FUNCT3_LH,  2'd0, 32'h80FF_1234, 1, 1'b1, 32'h0000_1234};
        tbl[7]  = '{"lw",        1'b1, 5'd12, WB_SEL_MEM, FUNCT3_LW,  2'd0, 32'h80FF_1234, 1, 1'b1, 32'h80FF_1234};
        tbl[8]  = '{"lbu_lo1",   1'b1, 5'd13, WB_SEL_MEM, FUNCT3_LBU, 2'd1, 32'h80FF_1234, 2, 1'b1, 32'h0000_0012};
        tbl[9]  = '{"lh_lo3",    1'b1, 5'd14, WB_SEL_MEM, FUNCT3_LH,  2'd3, 32'h80FF_1234, 1, 1'b1, 32'hFFFF_80FF};
        tbl[10] = '{"lbu_lo2",   1'b1, 5'd15, WB_SEL_MEM, FUNCT3_LBU, 2'd2, 32'h80FF_1234, 1, 1'b1, 32'h0000_00FF};
        tbl[11] = '{"lb_lo0",    1'b1, 5'd16, WB_SEL_MEM, FUNCT3_LB,  2'd0, 32'h0000_00F0, 1, 1'b1, 32'hFFFF_FFF0};
        tbl[12] = '{"lw_norw",   1'b0, 5'd17, WB_SEL_MEM, FUNCT3_LW,  2'd0, 32'h1234_5678, 1, 1'b0, 32'h1234_5678};
        tbl[13] = '{"lhu_lo1",   1'b1, 5'd18, WB_SEL_MEM, FUNCT3_LHU, 2'd1, 32'h80FF_1234, 1, 1'b1, 32'h0000_1234};
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst ready", bus.in_ready, 1);
        chk("rst we", bus.reg_write, 0);
        chk("rst rd", bus.rd, 0);
        chk("rst data", bus.rd_write_data, 0);
        chk("rst pend", bus.load_pending, 0);
        chk("rst pend_rd", bus.load_pending_rd, 0);
        chk("rst err", bus.protocol_err, 0);
        rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk({tbl[i].name, " ready"}, bus.in_ready, 1);
            present(tbl[i].rw, tbl[i].rd, tbl[i].sel, tbl[i].f3, tbl[i].lo, tbl[i].src);
            @(negedge clk);
            idle_inputs();
            if (tbl[i].sel == WB_SEL_MEM) begin
                for (int c = 0; c < tbl[i].lat; c++) begin
                    chk({tbl[i].name, " pend"}, bus.load_pending, 1);
                    chk({tbl[i].name, " pend_rd"}, bus.load_pending_rd, tbl[i].rd);
                    chk({tbl[i].name, " wait ready"}, bus.in_ready, 0);
                    chk({tbl[i].name, " wait we"}, bus.reg_write, 0);
                    if (c == tbl[i].lat - 1) begin
                        bus.dmem_rvalid = 1'b1;
                        bus.dmem_rdata  = tbl[i].src;
                    end
                    @(negedge clk);
                end
                bus.dmem_rvalid = 1'b0;
                chk({tbl[i].name, " pend clr"}, bus.load_pending, 0);
                chk({tbl[i].name, " pend_rd clr"}, bus.load_pending_rd, 0);
                chk({tbl[i].name, " ready back"}, bus.in_ready, 1);
            end
            chk({tbl[i].name, " we"}, bus.reg_write, tbl[i].exp_we);
            chk({tbl[i].name, " rd"}, bus.rd, tbl[i].rd);
            chk({tbl[i].name, " data"}, bus.rd_write_data, tbl[i].exp_data);
            chk({tbl[i].name, " err"}, bus.protocol_err, 0);
            @(negedge clk);
            chk({tbl[i].name, " we pulse"}, bus.reg_write, 0);
        end
        // back-to-back non-loads then a 1-cycle load with a held request during the wait
        @(negedge clk);
        present(1'b1, 5'd1, WB_SEL_ALU, 3'd0, 2'd0, 32'h0000_0011);
        @(negedge clk);
        present(1'b1, 5'd2, WB_SEL_ALU, 3'd0, 2'd0, 32'h0000_0022);
        chk("b2b we1", bus.reg_write, 1);
        chk("b2b rd1", bus.rd, 1);
        chk("b2b data1", bus.rd_write_data, 32'h11);
        @(negedge clk);
        present(1'b1, 5'd3, WB_SEL_IMM, 3'd0, 2'd0, 32'h0000_3000);
        chk("b2b we2", bus.reg_write, 1);
        chk("b2b rd2", bus.rd, 2);
        @(negedge clk);
        present(1'b1, 5'd4, WB_SEL_MEM, FUNCT3_LW, 2'd0, 32'h0);
        chk("b2b we3", bus.reg_write, 1);
        chk("b2b rd3", bus.rd, 3);
        chk("b2b data3", bus.rd_write_data, 32'h3000);
        @(negedge clk);
        present(1'b1, 5'd9, WB_SEL_ALU, 3'd0, 2'd0, 32'h0000_0099);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hCAFE_F00D;
        chk("b2b wait ready", bus.in_ready, 0);
        chk("b2b wait we", bus.reg_write, 0);
        chk("b2b wait pend_rd", bus.load_pending_rd, 4);
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        chk("b2b load we", bus.reg_write, 1);
        chk("b2b load rd", bus.rd, 4);
        chk("b2b load data", bus.rd_write_data, 32'hCAFE_F00D);
        chk("b2b load ready", bus.in_ready, 1);
        @(negedge clk);
        idle_inputs();
        chk("held we", bus.reg_write, 1);
        chk("held rd", bus.rd, 9);
        chk("held data", bus.rd_write_data, 32'h99);
        chk("b2b err", bus.protocol_err, 0);
        // reset in the middle of a load, then an orphan response
        @(negedge clk);
        present(1'b1, 5'd6, WB_SEL_MEM, FUNCT3_LW, 2'd0, 32'h0);
        @(negedge clk);
        idle_inputs();
        chk("mid pend", bus.load_pending, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst ready", bus.in_ready, 1);
        chk("mid rst pend", bus.load_pending, 0);
        chk("mid rst pend_rd", bus.load_pending_rd, 0);
        chk("mid rst we", bus.reg_write, 0);
        chk("mid rst rd", bus.rd, 0);
        chk("mid rst data", bus.rd_write_data, 0);
        @(negedge clk);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        chk("orphan we", bus.reg_write, 0);
        chk("orphan data", bus.rd_write_data, 0);
        chk("orphan err", bus.protocol_err, 1);
        repeat (3) @(negedge clk);
        chk("err sticky", bus.protocol_err, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err cleared", bus.protocol_err, 0);
        // undefined load width falls back to a word and flags an error
        @(negedge clk);
        present(1'b1, 5'd20, WB_SEL_MEM, 3'b011, 2'd2, 32'h0);
        @(negedge clk);
        idle_inputs();
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h80FF_1234;
        chk("f3_011 before err", bus.protocol_err, 0);
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        chk("f3_011 we", bus.reg_write, 1);
        chk("f3_011 rd", bus.rd, 20);
        chk("f3_011 data", bus.rd_write_data, 32'h80FF_1234);
        chk("f3_011 err", bus.protocol_err, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
